// File: rtl/ps2_move_pkg.sv
// Shared types and PS/2 protocol byte constants for the movement-key decoder.
// Tracked key codes are parameters of the decoder, not constants here.
package ps2_move_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } fsm_state_t;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    // Keyboard housekeeping replies: they abort any prefix but carry no key data.
    function automatic logic is_ignored(input logic [7:0] code);
        return (code == PS2_BAT) || (code == PS2_ACK) || (code == PS2_RESEND);
    endfunction

    function automatic logic is_error(input logic [7:0] code);
        return (code == PS2_ERR0) || (code == PS2_ERR1);
    endfunction

endpackage

// File: rtl/ps2_move_decoder_if.sv
// Byte stream from the keyboard receiver plus the frame-synchronous move/pause
// outputs consumed by the motion integrator.
interface ps2_move_decoder_if;

    logic       startOfFrame;
    logic       kbd_code_valid;
    logic [7:0] kbd_code;
    logic       moveLeft;
    logic       moveRight;
    logic       pause;
    logic       key_event;

    modport master (
        output startOfFrame, kbd_code_valid, kbd_code,
        input  moveLeft, moveRight, pause, key_event
    );

    modport slave (
        input  startOfFrame, kbd_code_valid, kbd_code,
        output moveLeft, moveRight, pause, key_event
    );

endinterface

// File: rtl/ps2_move_decoder.sv
// PS/2 scan-code decoder: prefix FSM, held-key tracking, stuck-key watchdog and
// a per-frame output sampler producing active-low moveLeft/moveRight and pause.
module ps2_move_decoder
    import ps2_move_pkg::*;
#(
    parameter logic [7:0]  KEY_LEFT_EXT  = 8'h6B,
    parameter logic [7:0]  KEY_RIGHT_EXT = 8'h74,
    parameter logic [7:0]  KEY_LEFT_ALT  = 8'h1C,
    parameter logic [7:0]  KEY_RIGHT_ALT = 8'h23,
    parameter logic [7:0]  KEY_PAUSE     = 8'h4D,
    parameter int unsigned STUCK_FRAMES  = 45
) (
    input  logic              clk,
    input  logic              reset,
    ps2_move_decoder_if.slave bus
);

    localparam logic [5:0] WD_LAST = 6'(STUCK_FRAMES - 1);

    fsm_state_t r_state, w_state_nxt;
    logic r_l_ext, r_l_alt, r_r_ext, r_r_alt;
    logic w_l_ext_nxt, w_l_alt_nxt, w_r_ext_nxt, w_r_alt_nxt;
    logic r_last_dir, w_last_dir_nxt;   // 0 = left, 1 = right
    logic r_p_held, w_p_held_nxt;
    logic r_pause_pend, w_pend_set;
    logic [5:0] r_wd_cnt, w_wd_cnt_nxt;
    logic w_wd_fire;
    logic r_move_left, r_move_right, r_pause, r_key_event;

    logic w_held_left, w_held_right, w_go_left, w_go_right;
    logic [7:0] w_code;

    assign w_code       = bus.kbd_code;
    assign w_held_left  = r_l_ext | r_l_alt;
    assign w_held_right = r_r_ext | r_r_alt;
    assign w_go_left    = w_held_left  & (~w_held_right | ~r_last_dir);
    assign w_go_right   = w_held_right & (~w_held_left  |  r_last_dir);

    // Watchdog only runs while a key is held and no bytes arrive.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_wd_fire    = 1'b0;
        w_wd_cnt_nxt = r_wd_cnt;
        if (bus.kbd_code_valid || !(w_held_left || w_held_right)) begin
            w_wd_cnt_nxt = '0;
        end else if (bus.startOfFrame) begin
            if (r_wd_cnt == WD_LAST) begin
                w_wd_fire    = 1'b1;
                w_wd_cnt_nxt = '0;
            end else begin
                w_wd_cnt_nxt = r_wd_cnt + 6'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_l_ext_nxt    = r_l_ext;
        w_l_alt_nxt    = r_l_alt;
        w_r_ext_nxt    = r_r_ext;
        w_r_alt_nxt    = r_r_alt;
        w_last_dir_nxt = r_last_dir;
        w_p_held_nxt   = r_p_held;
        w_pend_set     = 1'b0;

        if (bus.kbd_code_valid) begin
            w_state_nxt = IDLE;
            if (is_error(w_code)) begin
                {w_l_ext_nxt, w_l_alt_nxt, w_r_ext_nxt, w_r_alt_nxt} = 4'b0000;
                w_p_held_nxt = 1'b0;
            end else if (!is_ignored(w_code)) begin
                case (r_state)
                    IDLE: begin
                        if (w_code == PS2_EXT) begin
                            w_state_nxt = EXT;
                        end else if (w_code == PS2_BRK) begin
                            w_state_nxt = BRK;
                        end else if (w_code == KEY_LEFT_ALT && !r_l_alt) begin
                            w_l_alt_nxt    = 1'b1;
                            w_last_dir_nxt = 1'b0;
                        end else if (w_code == KEY_RIGHT_ALT && !r_r_alt) begin
                            w_r_alt_nxt    = 1'b1;
                            w_last_dir_nxt = 1'b1;
                        end else if (w_code == KEY_PAUSE && !r_p_held) begin
                            w_p_held_nxt = 1'b1;
                            w_pend_set   = 1'b1;
                        end
                    end
                    EXT: begin
                        if (w_code == PS2_BRK) begin
                            w_state_nxt = EXT_BRK;
                        end else if (w_code == PS2_EXT) begin
                            w_state_nxt = EXT;
                        end else if (w_code == KEY_LEFT_EXT && !r_l_ext) begin
                            w_l_ext_nxt    = 1'b1;
                            w_last_dir_nxt = 1'b0;
                        end else if (w_code == KEY_RIGHT_EXT && !r_r_ext) begin
                            w_r_ext_nxt    = 1'b1;
                            w_last_dir_nxt = 1'b1;
                        end
                    end
                    BRK: begin
                        if (w_code == PS2_EXT)            w_state_nxt  = EXT_BRK;
                        else if (w_code == KEY_LEFT_ALT)  w_l_alt_nxt  = 1'b0;
                        else if (w_code == KEY_RIGHT_ALT) w_r_alt_nxt  = 1'b0;
                        else if (w_code == KEY_PAUSE)     w_p_held_nxt = 1'b0;
                    end
                    EXT_BRK: begin
                        if (w_code == KEY_LEFT_EXT)       w_l_ext_nxt = 1'b0;
                        else if (w_code == KEY_RIGHT_EXT) w_r_ext_nxt = 1'b0;
                    end
                    default: w_state_nxt = IDLE;
                endcase
            end
        end else if (w_wd_fire) begin
            {w_l_ext_nxt, w_l_alt_nxt, w_r_ext_nxt, w_r_alt_nxt} = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_l_ext      <= 1'b0;
            r_l_alt      <= 1'b0;
            r_r_ext      <= 1'b0;
            r_r_alt      <= 1'b0;
            r_last_dir   <= 1'b0;
            r_p_held     <= 1'b0;
            r_pause_pend <= 1'b0;
            r_wd_cnt     <= '0;
            r_move_left  <= 1'b1;
            r_move_right <= 1'b1;
            r_pause      <= 1'b0;
            r_key_event  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            r_state      <= w_state_nxt;
            r_l_ext      <= w_l_ext_nxt;
            r_l_alt      <= w_l_alt_nxt;
            r_r_ext      <= w_r_ext_nxt;
            r_r_alt      <= w_r_alt_nxt;
            r_last_dir   <= w_last_dir_nxt;
            r_p_held     <= w_p_held_nxt;
            r_wd_cnt     <= w_wd_cnt_nxt;
            r_key_event  <= ((w_l_ext_nxt | w_l_alt_nxt) != w_held_left) |
                            ((w_r_ext_nxt | w_r_alt_nxt) != w_held_right);
            // A pause make landing on the sample cycle stays pending for next frame.
            r_pause_pend <= (r_pause_pend & ~bus.startOfFrame) | w_pend_set;
            if (bus.startOfFrame) begin
                r_move_left  <= ~w_go_left;
                r_move_right <= ~w_go_right;
                r_pause      <= r_pause ^ r_pause_pend;
            end
        end
    end

    assign bus.moveLeft  = r_move_left;
    assign bus.moveRight = r_move_right;
    assign bus.pause     = r_pause;
    assign bus.key_event = r_key_event;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Self-checking bench for ps2_move_decoder: table of byte vectors with expected
// frame outputs, plus hand-written watchdog, reset and same-cycle sequences.
module tb_ps2_move_decoder;
    import ps2_move_pkg::*;

    typedef struct {
        logic       l;
        logic       r;
        logic       p;
        int         tag;
    } exp_t;

    typedef struct {
        logic [31:0] bytes;   // first byte in [31:24]
        int          n;
        logic        l;
        logic        r;
        logic        p;
        int          ev;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic sof_d = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   ev_cnt = 0;
    exp_t sb_q[$];
    vec_t vecs[28];

    always #5 clk = ~clk;

    ps2_move_decoder_if bus ();

    ps2_move_decoder dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge clk) begin
        sof_d <= bus.startOfFrame;
        if (bus.key_event === 1'b1) ev_cnt <= ev_cnt + 1;
    end

    // Outputs of a sampling frame are compared one cycle after startOfFrame.
    always @(negedge clk) begin
        exp_t e;
        if (sof_d) begin
            check("scoreboard_has_entry", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check($sformatf("frame%0d_moveLeft", e.tag), bus.moveLeft, e.l);
                check($sformatf("frame%0d_moveRight", e.tag), bus.moveRight, e.r);
                check($sformatf("frame%0d_pause", e.tag), bus.pause, e.p);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.kbd_code       = b;
        bus.kbd_code_valid = 1'b1;
        @(negedge clk);
        bus.kbd_code_valid = 1'b0;
    endtask

    task automatic frame(input logic l, input logic r, input logic p, input int tag);
        exp_t e;
        e = '{l: l, r: r, p: p, tag: tag};
        @(negedge clk);
        bus.startOfFrame = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        bus.startOfFrame = 1'b0;
    endtask

    function automatic vec_t mk(input logic [31:0] bytes, input int n,
                                input logic l, input logic r, input logic p, input int ev);
        vec_t v;
        v = '{bytes: bytes, n: n, l: l, r: r, p: p, ev: ev};
        return v;
    endfunction

    initial begin : timeout
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin : main
        int ev0;
        logic [31:0] bb;

        vecs[0]  = mk({8'hE0, 8'h6B, 16'h0},        2, 0, 1, 0, 1);
        vecs[1]  = mk({8'hE0, 8'hF0, 8'h6B, 8'h0},  3, 1, 1, 0, 1);
        vecs[2]  = mk({8'hE0, 8'h6B, 8'h23, 8'h0},  3, 1, 0, 0, 2);
        vecs[3]  = mk({8'hF0, 8'h23, 16'h0},        2, 0, 1, 0, 1);
        vecs[4]  = mk({8'hE0, 8'h6B, 16'h0},        2, 0, 1, 0, 0);
        vecs[5]  = mk({8'h23, 24'h0},               1, 1, 0, 0, 1);
        vecs[6]  = mk({8'hE0, 8'hF0, 8'h6B, 8'h0},  3, 1, 0, 0, 1);
        vecs[7]  = mk({8'h1C, 24'h0},               1, 0, 1, 0, 1);
        vecs[8]  = mk({8'hE0, 8'h6B, 16'h0},        2, 0, 1, 0, 0);
        vecs[9]  = mk({8'hF0, 8'h1C, 16'h0},        2, 0, 1, 0, 0);
        vecs[10] = mk({8'hE0, 8'hF0, 8'h6B, 8'h0},  3, 1, 0, 0, 1);
        vecs[11] = mk({8'hF0, 8'h23, 16'h0},        2, 1, 1, 0, 1);
        vecs[12] = mk({8'hE0, 8'hFA, 8'h6B, 8'h0},  3, 1, 1, 0, 0);
        vecs[13] = mk({8'hE0, 8'h6B, 8'hAA, 8'h0},  3, 0, 1, 0, 1);
        vecs[14] = mk({8'hFF, 24'h0},               1, 1, 1, 0, 1);
        vecs[15] = mk({8'h4D, 8'h4D, 16'h0},        2, 1, 1, 1, 0);
        vecs[16] = mk({8'h4D, 24'h0},               1, 1, 1, 1, 0);
        vecs[17] = mk({8'hF0, 8'h4D, 16'h0},        2, 1, 1, 1, 0);
        vecs[18] = mk({8'h4D, 24'h0},               1, 1, 1, 0, 0);
        vecs[19] = mk({8'hF0, 8'h4D, 16'h0},        2, 1, 1, 0, 0);
        vecs[20] = mk({8'h4D, 24'h0},               1, 1, 1, 1, 0);
        vecs[21] = mk({8'hFF, 24'h0},               1, 1, 1, 1, 0);
        vecs[22] = mk({8'h4D, 24'h0},               1, 1, 1, 0, 0);
        vecs[23] = mk({8'hE0, 8'hE0, 8'h74, 8'h0},  3, 1, 0, 0, 1);
        vecs[24] = mk({8'hF0, 8'hE0, 8'h74, 8'h0},  3, 1, 1, 0, 1);
        vecs[25] = mk({8'h1C, 24'h0},               1, 0, 1, 0, 1);
        vecs[26] = mk({8'hE0, 8'hF0, 8'h1C, 8'h0},  3, 0, 1, 0, 0);
        vecs[27] = mk({8'hF0, 8'h1C, 16'h0},        2, 1, 1, 0, 1);

        bus.startOfFrame   = 1'b0;
        bus.kbd_code_valid = 1'b0;
        bus.kbd_code       = 8'h00;
        reset              = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(1);
        check("reset_moveLeft", bus.moveLeft, 1'b1);
        check("reset_moveRight", bus.moveRight, 1'b1);
        check("reset_pause", bus.pause, 1'b0);
        check("reset_key_event", bus.key_event, 1'b0);

        for (int i = 0; i < 28; i++) begin
            ev0 = ev_cnt;
            bb  = vecs[i].bytes;
            for (int k = 0; k < vecs[i].n; k++) send_byte(bb[31 - 8*k -: 8]);
            frame(vecs[i].l, vecs[i].r, vecs[i].p, i);
            idle(2);
            check($sformatf("vec%0d_key_event_count", i), 32'(ev_cnt - ev0), 32'(vecs[i].ev));
        end

        // Stuck right arrow: released by the watchdog on the 45th quiet frame.
        ev0 = ev_cnt;
        send_byte(PS2_EXT);
        send_byte(8'h74);
        for (int f = 1; f <= 44; f++) frame(1, 0, 0, 100 + f);
        idle(2);
        check("wd_events_before_expiry", 32'(ev_cnt - ev0), 32'd1);
        frame(1, 0, 0, 145);
        idle(2);
        check("wd_events_after_expiry", 32'(ev_cnt - ev0), 32'd2);
        frame(1, 1, 0, 146);

        // Typematic repeat at frame 30 restarts the watchdog.
        ev0 = ev_cnt;
        send_byte(PS2_EXT);
        send_byte(8'h74);
        for (int f = 1; f <= 29; f++) frame(1, 0, 0, 200 + f);
        send_byte(PS2_EXT);
        send_byte(8'h74);
        for (int f = 30; f <= 50; f++) frame(1, 0, 0, 200 + f);
        idle(2);
        check("wd_repeat_events", 32'(ev_cnt - ev0), 32'd1);
        send_byte(PS2_EXT);
        send_byte(PS2_BRK);
        send_byte(8'h74);
        frame(1, 1, 0, 251);

        // Reset after a lone E0 must drop the prefix.
        send_byte(PS2_EXT);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_key_event", bus.key_event, 1'b0);
        ev0 = ev_cnt;
        send_byte(8'h6B);
        frame(1, 1, 0, 260);
        idle(2);
        check("midreset_no_events", 32'(ev_cnt - ev0), 32'd0);

        // Completing byte coincides with startOfFrame: visible one frame later.
        send_byte(PS2_EXT);
        @(negedge clk);
        bus.kbd_code       = 8'h6B;
        bus.kbd_code_valid = 1'b1;
        bus.startOfFrame   = 1'b1;
        sb_q.push_back('{l: 1'b1, r: 1'b1, p: 1'b0, tag: 300});
        @(negedge clk);
        bus.kbd_code_valid = 1'b0;
        bus.startOfFrame   = 1'b0;
        frame(0, 1, 0, 301);
        send_byte(PS2_ERR1);
        frame(1, 1, 0, 302);

        idle(3);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
